// File: rtl/spi_fifo_param_if.sv
// rtl/spi_fifo_param_if.sv - handshake/data bundle between the SPI FIFO and its user
// Optional error-flag signals exist only when SPI_FIFO_ERR_FLAGS_EN is defined.
interface spi_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             flush;
  logic             write_ready;
  logic [WIDTH-1:0] Rx_dataIn;
  logic             read_ready;
  logic [WIDTH-1:0] Rx_DataOut;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             ALMOST_EMPTY;
  logic [LW-1:0]    level;
`ifdef SPI_FIFO_ERR_FLAGS_EN
  logic             OVERFLOW;
  logic             UNDERFLOW;
  logic             err_clr;
`endif

`ifdef SPI_FIFO_ERR_FLAGS_EN
  modport master (
    output flush, write_ready, Rx_dataIn, read_ready, err_clr,
    input  Rx_DataOut, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, level, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  flush, write_ready, Rx_dataIn, read_ready, err_clr,
    output Rx_DataOut, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, level, OVERFLOW, UNDERFLOW
  );
`else
  modport master (
    output flush, write_ready, Rx_dataIn, read_ready,
    input  Rx_DataOut, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, level
  );
  modport slave (
    input  flush, write_ready, Rx_dataIn, read_ready,
    output Rx_DataOut, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, level
  );
`endif
endinterface

// File: rtl/spi_fifo_param.sv
// rtl/spi_fifo_param.sv - parametrised first-word-fall-through circular FIFO for SPI traffic
// Optional sticky OVERFLOW/UNDERFLOW flags: define SPI_FIFO_ERR_FLAGS_EN.
module spi_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input logic               Master_clk,
  input logic               rst,
  spi_fifo_param_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] AF_L = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L = LW'(AE_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_fifo_param: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("spi_fifo_param: AF_LEVEL=%0d outside 0..DEPTH", AF_LEVEL);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
    $error("spi_fifo_param: AE_LEVEL=%0d outside 0..DEPTH", AE_LEVEL);
  end
  if ($bits(bus.Rx_DataOut) != WIDTH) begin : g_bad_width
    $error("spi_fifo_param: interface WIDTH does not match module WIDTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_nxt;
  logic             empty_q;
  logic             full_q;
  logic             af_q;
  logic             ae_q;
  logic             wr_acc;
  logic             rd_acc;

  // Accept decisions and next fill level; a pop while full frees the slot the push uses.
  always_comb begin
    rd_acc    = bus.read_ready & ~empty_q;
    wr_acc    = bus.write_ready & (~full_q | bus.read_ready);
    level_nxt = level_q;
    if (wr_acc && !rd_acc) begin
      level_nxt = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_nxt = level_q - LW'(1);
    end
  end

  // Pointer/level datapath; flags are registered from the next level so they never lag.
  always_ff @(posedge Master_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      level_q <= level_nxt;
      empty_q <= (level_nxt == '0);
      full_q  <= (level_nxt == LW'(DEPTH));
      af_q    <= (level_nxt >= AF_L);
      ae_q    <= (level_nxt <= AE_L);
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge Master_clk) begin
    if (wr_acc && !bus.flush) begin
      mem[wr_ptr] <= bus.Rx_dataIn;
    end
  end

  assign bus.Rx_DataOut   = empty_q ? '0 : mem[rd_ptr];
  assign bus.EMPTY        = empty_q;
  assign bus.FULL         = full_q;
  assign bus.ALMOST_FULL  = af_q;
  assign bus.ALMOST_EMPTY = ae_q;
  assign bus.level        = level_q;

`ifdef SPI_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;
  logic ovf_set;
  logic udf_set;

  assign ovf_set = bus.write_ready & ~wr_acc;
  assign udf_set = bus.read_ready & empty_q & ~wr_acc;

  // Sticky error flags; a new event in the same cycle beats err_clr.
  always_ff @(posedge Master_clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
      udf_q <= udf_set | (udf_q & ~bus.err_clr);
    end
  end

  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = udf_q;
`endif
endmodule

// File: tb/tb_spi_fifo_param.sv
// tb/tb_spi_fifo_param.sv - self-checking bench for spi_fifo_param against a queue model
module tb_spi_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  spi_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .Master_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] q[$];
  bit m_ovf;
  bit m_udf;

  function automatic logic [7:0] exp_dout();
    return (q.size() == 0) ? 8'h00 : q[0];
  endfunction

  // Reference behaviour: a queue bounded at DEPTH, updated from pre-edge occupancy.
  task automatic model_step(input bit wr, input logic [7:0] d, input bit rd, input bit fl, input bit clr);
    bit was_full, was_empty, wacc, racc;
    if (fl) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    racc = rd && !was_empty;
    wacc = wr && (!was_full || rd);
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(d);
    m_ovf = (wr && !wacc) || (m_ovf && !clr);
    m_udf = (rd && was_empty && !wacc) || (m_udf && !clr);
  endtask

  task automatic do_cycle(input bit wr, input logic [7:0] d, input bit rd, input bit fl, input bit clr);
    bus.write_ready = wr;
    bus.Rx_dataIn   = d;
    bus.read_ready  = rd;
    bus.flush       = fl;
`ifdef SPI_FIFO_ERR_FLAGS_EN
    bus.err_clr     = clr;
`endif
    @(posedge clk);
    model_step(wr, d, rd, fl, clr);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.write_ready = 0; bus.read_ready = 0; bus.flush = 0; bus.Rx_dataIn = '0;
`ifdef SPI_FIFO_ERR_FLAGS_EN
    bus.err_clr = 0;
`endif
    q.delete(); m_ovf = 0; m_udf = 0;
    #12;
    checks++; if (bus.level !== 4'd0) $display("FAIL reset_level act=%0d exp=0", bus.level); else passed++;
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL reset_empty act=%b exp=1", bus.EMPTY); else passed++;
    checks++; if (bus.FULL !== 1'b0) $display("FAIL reset_full act=%b exp=0", bus.FULL); else passed++;
    checks++; if (bus.ALMOST_EMPTY !== 1'b1) $display("FAIL reset_ae act=%b exp=1", bus.ALMOST_EMPTY); else passed++;
    checks++; if (bus.ALMOST_FULL !== 1'b0) $display("FAIL reset_af act=%b exp=0", bus.ALMOST_FULL); else passed++;
    checks++; if (bus.Rx_DataOut !== 8'h00) $display("FAIL reset_dout act=%h exp=00", bus.Rx_DataOut); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic_write();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, vals[i], 0, 0, 0);
      checks++; if (bus.level !== 4'(i + 1)) $display("FAIL basic_level%0d act=%0d exp=%0d", i, bus.level, i + 1); else passed++;
      checks++; if (bus.Rx_DataOut !== 8'h11) $display("FAIL basic_dout%0d act=%h exp=11", i, bus.Rx_DataOut); else passed++;
      checks++; if (bus.EMPTY !== 1'b0) $display("FAIL basic_empty%0d act=%b exp=0", i, bus.EMPTY); else passed++;
      checks++; if (bus.ALMOST_EMPTY !== (i == 0)) $display("FAIL basic_ae%0d act=%b exp=%b", i, bus.ALMOST_EMPTY, i == 0); else passed++;
    end
  endtask

  task automatic test_fill_overflow();
    do_cycle(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1, 8'hA0 + 8'(i), 0, 0, 0);
      checks++; if (bus.ALMOST_FULL !== (i + 1 >= AF)) $display("FAIL fill_af%0d act=%b exp=%b", i, bus.ALMOST_FULL, i + 1 >= AF); else passed++;
      checks++; if (bus.FULL !== (i + 1 == DEPTH)) $display("FAIL fill_full%0d act=%b exp=%b", i, bus.FULL, i + 1 == DEPTH); else passed++;
    end
    do_cycle(1, 8'hFF, 0, 0, 0);
    checks++; if (bus.level !== 4'd8) $display("FAIL ovf_level act=%0d exp=8", bus.level); else passed++;
    checks++; if (bus.FULL !== 1'b1) $display("FAIL ovf_full act=%b exp=1", bus.FULL); else passed++;
    checks++; if (bus.Rx_DataOut !== 8'hA0) $display("FAIL ovf_dout act=%h exp=a0", bus.Rx_DataOut); else passed++;
`ifdef SPI_FIFO_ERR_FLAGS_EN
    checks++; if (bus.OVERFLOW !== 1'b1) $display("FAIL ovf_flag act=%b exp=1", bus.OVERFLOW); else passed++;
`endif
  endtask

  task automatic test_full_rw_wrap();
    logic [7:0] exp_seq [8];
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'hA1 + 8'(i);
    exp_seq[7] = 8'h5A;
    do_cycle(1, 8'h5A, 1, 0, 0);
    checks++; if (bus.level !== 4'd8) $display("FAIL fullrw_level act=%0d exp=8", bus.level); else passed++;
    checks++; if (bus.Rx_DataOut !== 8'hA1) $display("FAIL fullrw_dout act=%h exp=a1", bus.Rx_DataOut); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.Rx_DataOut !== exp_seq[i]) $display("FAIL wrap_pop%0d act=%h exp=%h", i, bus.Rx_DataOut, exp_seq[i]); else passed++;
      do_cycle(0, 8'h00, 1, 0, 0);
    end
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL wrap_empty act=%b exp=1", bus.EMPTY); else passed++;
  endtask

  task automatic test_empty_rw();
    do_cycle(1, 8'h77, 1, 0, 1);
    checks++; if (bus.level !== 4'd1) $display("FAIL emptyrw_level act=%0d exp=1", bus.level); else passed++;
    checks++; if (bus.Rx_DataOut !== 8'h77) $display("FAIL emptyrw_dout act=%h exp=77", bus.Rx_DataOut); else passed++;
`ifdef SPI_FIFO_ERR_FLAGS_EN
    checks++; if (bus.UNDERFLOW !== 1'b0) $display("FAIL emptyrw_udf act=%b exp=0", bus.UNDERFLOW); else passed++;
    checks++; if (bus.OVERFLOW !== 1'b0) $display("FAIL errclr_ovf act=%b exp=0", bus.OVERFLOW); else passed++;
`endif
    do_cycle(0, 8'h00, 1, 0, 0);
    do_cycle(0, 8'h00, 1, 0, 0);
    checks++; if (bus.level !== 4'd0) $display("FAIL underread_level act=%0d exp=0", bus.level); else passed++;
`ifdef SPI_FIFO_ERR_FLAGS_EN
    checks++; if (bus.UNDERFLOW !== 1'b1) $display("FAIL udf_set act=%b exp=1", bus.UNDERFLOW); else passed++;
    do_cycle(0, 8'h00, 0, 0, 1);
    checks++; if (bus.UNDERFLOW !== 1'b0) $display("FAIL udf_clr act=%b exp=0", bus.UNDERFLOW); else passed++;
`endif
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) do_cycle(1, 8'h30 + 8'(i), 0, 0, 0);
    checks++; if (bus.level !== 4'd5) $display("FAIL flush_pre_level act=%0d exp=5", bus.level); else passed++;
    do_cycle(1, 8'hEE, 0, 1, 0);
    checks++; if (bus.level !== 4'd0) $display("FAIL flush_level act=%0d exp=0", bus.level); else passed++;
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL flush_empty act=%b exp=1", bus.EMPTY); else passed++;
    checks++; if (bus.ALMOST_FULL !== 1'b0) $display("FAIL flush_af act=%b exp=0", bus.ALMOST_FULL); else passed++;
    checks++; if (bus.Rx_DataOut !== 8'h00) $display("FAIL flush_dout act=%h exp=00", bus.Rx_DataOut); else passed++;
    do_cycle(1, 8'h12, 0, 0, 0);
    checks++; if (bus.Rx_DataOut !== 8'h12) $display("FAIL flush_after_dout act=%h exp=12", bus.Rx_DataOut); else passed++;
    checks++; if (bus.level !== 4'd1) $display("FAIL flush_after_level act=%0d exp=1", bus.level); else passed++;
    do_cycle(0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) do_cycle(1, 8'h40 + 8'(i), 0, 0, 0);
    bus.write_ready = 1; bus.Rx_dataIn = 8'h99; bus.read_ready = 0;
    #3;
    rst = 1'b1;
    q.delete(); m_ovf = 0; m_udf = 0;
    #1;
    checks++; if (bus.level !== 4'd0) $display("FAIL arst_level act=%0d exp=0", bus.level); else passed++;
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL arst_empty act=%b exp=1", bus.EMPTY); else passed++;
    checks++; if (bus.ALMOST_EMPTY !== 1'b1) $display("FAIL arst_ae act=%b exp=1", bus.ALMOST_EMPTY); else passed++;
    checks++; if (bus.Rx_DataOut !== 8'h00) $display("FAIL arst_dout act=%h exp=00", bus.Rx_DataOut); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.level !== 4'd0) $display("FAIL arst_hold_level act=%0d exp=0", bus.level); else passed++;
    #2;
    rst = 1'b0;
    do_cycle(1, 8'hC3, 0, 0, 0);
    checks++; if (bus.Rx_DataOut !== 8'hC3) $display("FAIL arst_first_dout act=%h exp=c3", bus.Rx_DataOut); else passed++;
    checks++; if (dut.mem[0] !== 8'hC3) $display("FAIL arst_entry0 act=%h exp=c3", dut.mem[0]); else passed++;
    checks++; if (bus.level !== 4'd1) $display("FAIL arst_first_level act=%0d exp=1", bus.level); else passed++;
  endtask

  task automatic test_random();
    bit wr, rd, fl, clr;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      fl  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 19) == 0);
      d   = 8'($urandom);
      do_cycle(wr, d, rd, fl, clr);
      checks++; if (bus.level !== 4'(q.size())) $display("FAIL rnd_level%0d act=%0d exp=%0d", i, bus.level, q.size()); else passed++;
      checks++; if (bus.Rx_DataOut !== exp_dout()) $display("FAIL rnd_dout%0d act=%h exp=%h", i, bus.Rx_DataOut, exp_dout()); else passed++;
      checks++; if (bus.EMPTY !== (q.size() == 0)) $display("FAIL rnd_empty%0d act=%b exp=%b", i, bus.EMPTY, q.size() == 0); else passed++;
      checks++; if (bus.FULL !== (q.size() == DEPTH)) $display("FAIL rnd_full%0d act=%b exp=%b", i, bus.FULL, q.size() == DEPTH); else passed++;
      checks++; if (bus.ALMOST_FULL !== (q.size() >= AF)) $display("FAIL rnd_af%0d act=%b exp=%b", i, bus.ALMOST_FULL, q.size() >= AF); else passed++;
      checks++; if (bus.ALMOST_EMPTY !== (q.size() <= AE)) $display("FAIL rnd_ae%0d act=%b exp=%b", i, bus.ALMOST_EMPTY, q.size() <= AE); else passed++;
`ifdef SPI_FIFO_ERR_FLAGS_EN
      checks++; if (bus.OVERFLOW !== m_ovf) $display("FAIL rnd_ovf%0d act=%b exp=%b", i, bus.OVERFLOW, m_ovf); else passed++;
      checks++; if (bus.UNDERFLOW !== m_udf) $display("FAIL rnd_udf%0d act=%b exp=%b", i, bus.UNDERFLOW, m_udf); else passed++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_fill_overflow();
    test_full_rw_wrap();
    test_empty_rw();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
